// File: rtl/shift_ext_pipe.sv
// Elastic extend-then-shift unit (SLL/SRL/SRA) with significance-loss flag.
// Latency STAGES cycles, capacity STAGES; stalls ripple back combinationally to in_ready.
module shift_ext_pipe #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int SHW    = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    input  logic [1:0]       in_op,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    typedef struct packed {
        logic [OUT_W-1:0] dat;
        logic [SHW-1:0]   shamt;
        logic [1:0]       op;
        logic             sgn;
        logic             ovf;
    } stage_t;

    localparam int BASE  = SHW / STAGES;
    localparam int EXTRA = SHW % STAGES;

    // Earlier stages absorb the leftover mux levels.
    function automatic int lvl_lo(input int k);
        return k * BASE + ((k < EXTRA) ? k : EXTRA);
    endfunction

    function automatic int lvl_n(input int k);
        return BASE + ((k < EXTRA) ? 1 : 0);
    endfunction

    // Bits pushed out by a left shift of s; signed operands also lose
    // significance when the new MSB disagrees with anything shifted out.
    function automatic logic lost_bits(input logic [OUT_W-1:0] v, input logic sgn, input int s);
        logic lost;
        int   ref_b;
        lost  = 1'b0;
        ref_b = 0;
        if (s >= OUT_W) begin
            lost = |v;
        end else begin
            ref_b = OUT_W - 1 - s;
            for (int b = 0; b < OUT_W; b++) begin
                if (b >= OUT_W - s) begin
                    lost = lost | (sgn ? (v[b] != v[ref_b]) : v[b]);
                end
            end
        end
        return lost;
    endfunction

    function automatic stage_t apply_levels(input stage_t st, input int lo, input int n);
        stage_t r;
        int     s;
        logic   left;
        logic   arith;
        r     = st;
        s     = 0;
        left  = (st.op == 2'b00) || (st.op == 2'b11);
        arith = (st.op == 2'b10) && st.sgn;
        for (int i = 0; i < SHW; i++) begin
            if (i >= lo && i < lo + n && st.shamt[i]) begin
                s = 1 << i;
                if (left) begin
                    r.ovf = r.ovf | lost_bits(r.dat, r.sgn, s);
                    r.dat = r.dat << s;
                end else if (arith) begin
                    r.dat = $signed(r.dat) >>> s;
                end else begin
                    r.dat = r.dat >> s;
                end
            end
        end
        return r;
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] adv;
    stage_t            stg_q [STAGES];
    stage_t            stg_d [STAGES];
    stage_t            src   [STAGES];
    stage_t            in_st;

    always_comb begin
        in_st       = '0;
        in_st.dat   = OUT_W'(in_data);
        if (in_signed && in_data[IN_W-1]) begin
            in_st.dat = in_st.dat | ({OUT_W{1'b1}} << IN_W);
        end
        in_st.shamt = in_shamt;
        in_st.op    = in_op;
        in_st.sgn   = in_signed;
        in_st.ovf   = 1'b0;
    end

    // A stage moves when it is empty or its successor moves.
    always_comb begin
        logic a;
        adv = '0;
        a   = ~vld_q[STAGES-1] | out_ready;
        adv[STAGES-1] = a;
        for (int k = STAGES - 2; k >= 0; k--) begin
            a      = ~vld_q[k] | a;
            adv[k] = a;
        end
    end

    always_comb begin
        vld_d    = '0;
        src[0]   = in_st;
        vld_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src[k]   = stg_q[k-1];
            vld_d[k] = vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            stg_d[k] = apply_levels(src[k], lvl_lo(k), lvl_n(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= vld_d[k];
                    stg_q[k] <= stg_d[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = stg_q[STAGES-1].dat;
    assign out_ovf   = stg_q[STAGES-1].ovf;

endmodule

// File: tb/tb_shift_ext_pipe.sv
// Bench for shift_ext_pipe: small 3->6 bit two-stage instance and 8->16 bit four-stage instance.
module tb_shift_ext_pipe;

    logic clk;
    logic rst;

    logic       a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_ovf;
    logic [2:0] a_in_data, a_in_shamt;
    logic [1:0] a_in_op;
    logic [5:0] a_out_data;

    logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_ovf;
    logic [7:0]  b_in_data;
    logic [4:0]  b_in_shamt;
    logic [1:0]  b_in_op;
    logic [15:0] b_out_data;

    int checks   = 0;
    int failures = 0;

    shift_ext_pipe #(.IN_W(3), .OUT_W(6), .SHW(3), .STAGES(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_signed(a_in_signed), .in_op(a_in_op), .in_shamt(a_in_shamt),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf)
    );

    shift_ext_pipe #(.IN_W(8), .OUT_W(16), .SHW(5), .STAGES(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_signed(b_in_signed), .in_op(b_in_op), .in_shamt(b_in_shamt),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the extended operand value.
    function automatic void ref_shift(input int in_w, input int out_w, input logic [7:0] d,
                                      input bit sgn, input logic [1:0] op, input int sh,
                                      output logic [15:0] r, output bit ovf);
        longint lim, u, x, full;
        lim = longint'(1) << out_w;
        u   = longint'(d) & ((longint'(1) << in_w) - 1);
        x   = u;
        if (sgn && u >= (longint'(1) << (in_w - 1))) x = u - (longint'(1) << in_w);
        ovf = 1'b0;
        if (op == 2'b01 || (op == 2'b10 && !sgn)) begin
            full = (x + lim) % lim;
            r    = 16'(full >> sh);
        end else if (op == 2'b10) begin
            full = x >>> sh;
            r    = 16'((full + lim) % lim);
        end else begin
            full = x * (longint'(1) << sh);
            r    = 16'(((full % lim) + lim) % lim);
            ovf  = sgn ? (full < -(lim / 2) || full >= lim / 2) : (full >= lim);
        end
    endfunction

    typedef struct {
        logic       sgn;
        logic [1:0] op;
        logic [2:0] d;
        logic [2:0] sh;
        logic [5:0] ed;
        logic       eo;
    } vec_t;

    vec_t vt [16];

    initial begin
        logic [15:0] r;
        bit          o;
        logic [16:0] expq [$];
        logic [16:0] e;
        logic [2:0]  bp_d  [4];
        logic [1:0]  bp_op [4];
        logic [2:0]  bp_sh [4];
        logic        bp_sg [4];
        logic [15:0] bp_e  [2];
        bit          bp_o  [2];
        int          acc, idx, sent, got, cyc, cnt;
        bit          taken, held_vld;
        logic [16:0] held;
        logic [7:0]  pd;
        logic        ps;
        logic [1:0]  pop;
        logic [4:0]  psh;

        vt[0]  = '{1'b0, 2'b00, 3'b100, 3'd1, 6'b001000, 1'b0};
        vt[1]  = '{1'b1, 2'b00, 3'b100, 3'd1, 6'b111000, 1'b0};
        vt[2]  = '{1'b1, 2'b10, 3'b110, 3'd1, 6'b111111, 1'b0};
        vt[3]  = '{1'b0, 2'b10, 3'b110, 3'd1, 6'b000011, 1'b0};
        vt[4]  = '{1'b1, 2'b01, 3'b110, 3'd1, 6'b011111, 1'b0};
        vt[5]  = '{1'b1, 2'b00, 3'b100, 3'd3, 6'b100000, 1'b0};
        vt[6]  = '{1'b1, 2'b00, 3'b100, 3'd4, 6'b000000, 1'b1};
        vt[7]  = '{1'b0, 2'b00, 3'b100, 3'd7, 6'b000000, 1'b1};
        vt[8]  = '{1'b1, 2'b10, 3'b100, 3'd7, 6'b111111, 1'b0};
        vt[9]  = '{1'b0, 2'b11, 3'b011, 3'd2, 6'b001100, 1'b0};
        vt[10] = '{1'b0, 2'b00, 3'b111, 3'd4, 6'b110000, 1'b1};
        vt[11] = '{1'b1, 2'b00, 3'b011, 3'd3, 6'b011000, 1'b0};
        vt[12] = '{1'b1, 2'b00, 3'b011, 3'd4, 6'b110000, 1'b1};
        vt[13] = '{1'b1, 2'b10, 3'b111, 3'd7, 6'b111111, 1'b0};
        vt[14] = '{1'b0, 2'b01, 3'b101, 3'd7, 6'b000000, 1'b0};
        vt[15] = '{1'b1, 2'b01, 3'b100, 3'd0, 6'b111100, 1'b0};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_in_signed = 0; a_in_op = '0; a_in_shamt = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_signed = 0; b_in_op = '0; b_in_shamt = '0; b_out_ready = 1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data", a_out_data, 0);
        chk("rst_a_out_ovf", a_out_ovf, 0);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            chk("idle_b_out_valid", b_out_valid, 0);
        end

        // Directed vectors, one at a time, latency observed for each.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_in_valid = 1; a_in_signed = vt[i].sgn; a_in_op = vt[i].op;
            a_in_data = vt[i].d; a_in_shamt = vt[i].sh;
            #1 chk($sformatf("vec%0d_in_ready", i), a_in_ready, 1);
            @(negedge clk);
            a_in_valid = 0;
            #1 chk($sformatf("vec%0d_early_valid", i), a_out_valid, 0);
            @(negedge clk); #1;
            chk($sformatf("vec%0d_valid", i), a_out_valid, 1);
            chk($sformatf("vec%0d_data", i), a_out_data, vt[i].ed);
            chk($sformatf("vec%0d_ovf", i), a_out_ovf, vt[i].eo);
        end

        // Back-to-back at full rate: in_ready never drops.
        expq.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                a_in_valid = 1; a_in_signed = 1'($urandom); a_in_op = 2'($urandom);
                a_in_data = 3'($urandom); a_in_shamt = 3'($urandom);
                ref_shift(3, 6, {5'b0, a_in_data}, a_in_signed, a_in_op, int'(a_in_shamt), r, o);
                expq.push_back({o, r});
            end else begin
                a_in_valid = 0;
            end
            #1;
            chk("tput_in_ready", a_in_ready, 1);
            chk($sformatf("tput_valid_c%0d", c), a_out_valid, (c >= 2));
            if (a_out_valid && expq.size() > 0) begin
                e = expq.pop_front();
                chk("tput_data", a_out_data, e[15:0]);
                chk("tput_ovf", a_out_ovf, e[16]);
            end
        end

        // Backpressure: only STAGES items fit while the consumer stalls.
        bp_d  = '{3'b001, 3'b010, 3'b011, 3'b101};
        bp_op = '{2'b00, 2'b00, 2'b01, 2'b10};
        bp_sh = '{3'd1, 3'd2, 3'd1, 3'd1};
        bp_sg = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            ref_shift(3, 6, {5'b0, bp_d[k]}, bp_sg[k], bp_op[k], int'(bp_sh[k]), bp_e[k], bp_o[k]);
        end
        acc = 0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_out_ready = 0; a_in_valid = 1;
            a_in_data = bp_d[idx]; a_in_op = bp_op[idx]; a_in_shamt = bp_sh[idx]; a_in_signed = bp_sg[idx];
            #1;
            chk($sformatf("bp_in_ready_c%0d", c), a_in_ready, (c < 2));
            if (c >= 2) begin
                chk("bp_hold_valid", a_out_valid, 1);
                chk("bp_hold_data", a_out_data, bp_e[0][5:0]);
                chk("bp_hold_ovf", a_out_ovf, bp_o[0]);
            end
            if (a_in_valid && a_in_ready) begin
                acc++; idx++;
            end
        end
        chk("bp_accepted", acc, 2);
        @(negedge clk);
        a_in_valid = 0; a_out_ready = 1;
        #1;
        chk("bp_release_in_ready", a_in_ready, 1);
        chk("bp_drain0_valid", a_out_valid, 1);
        chk("bp_drain0_data", a_out_data, bp_e[0][5:0]);
        @(negedge clk); #1;
        chk("bp_drain1_valid", a_out_valid, 1);
        chk("bp_drain1_data", a_out_data, bp_e[1][5:0]);
        chk("bp_drain1_ovf", a_out_ovf, bp_o[1]);
        @(negedge clk); #1;
        chk("bp_drained", a_out_valid, 0);

        // Random streaming on the wide instance with a stuttering consumer.
        expq.delete();
        sent = 0; got = 0; cyc = 0; taken = 0; held_vld = 0; held = '0;
        while (got < 100 && cyc < 5000) begin
            @(negedge clk);
            if (taken) b_in_valid = 0;
            taken = 0;
            if (!b_in_valid && sent < 100 && $urandom_range(0, 9) < 8) begin
                b_in_valid = 1; b_in_data = 8'($urandom); b_in_signed = 1'($urandom);
                b_in_op = 2'($urandom_range(0, 3)); b_in_shamt = 5'($urandom_range(0, 31));
            end
            b_out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (held_vld) begin
                chk("stream_hold_valid", b_out_valid, 1);
                chk("stream_hold_result", {b_out_ovf, b_out_data}, held);
            end
            held_vld = b_out_valid && !b_out_ready;
            held     = {b_out_ovf, b_out_data};
            if (b_out_valid && b_out_ready) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stream_extra: got result %0h with nothing outstanding", b_out_data);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("stream_item%0d", got), {b_out_ovf, b_out_data}, e);
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                ref_shift(8, 16, b_in_data, b_in_signed, b_in_op, int'(b_in_shamt), r, o);
                expq.push_back({o, r});
                sent++;
                taken = 1;
            end
            cyc++;
        end
        @(negedge clk);
        b_in_valid = 0;
        chk("stream_received", got, 100);
        chk("stream_sent", sent, 100);

        // Asynchronous reset with items in flight.
        b_out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            b_in_valid = 1; b_in_data = 8'(8'h81 + k); b_in_signed = 1; b_in_op = 2'b00; b_in_shamt = 5'd3;
        end
        @(negedge clk);
        b_in_valid = 0;
        repeat (2) @(negedge clk);
        #1 chk("rstmid_before_valid", b_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_valid", b_out_valid, 0);
        chk("rstmid_data", b_out_data, 0);
        chk("rstmid_ovf", b_out_ovf, 0);
        chk("rstmid_in_ready", b_in_ready, 1);
        @(negedge clk);
        rst = 1'b0; b_out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("rstmid_no_stale", b_out_valid, 0);
        end
        @(negedge clk);
        b_in_valid = 1; b_in_data = 8'hC3; b_in_signed = 1; b_in_op = 2'b10; b_in_shamt = 5'd2;
        ref_shift(8, 16, b_in_data, 1'b1, 2'b10, 2, r, o);
        #1 chk("rstmid_accept_ready", b_in_ready, 1);
        cnt = 0;
        while (cnt < 10) begin
            @(negedge clk);
            b_in_valid = 0;
            cnt++;
            #1;
            if (b_out_valid) break;
        end
        chk("rstmid_latency", cnt, 4);
        chk("rstmid_data_after", b_out_data, r);
        chk("rstmid_ovf_after", b_out_ovf, o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_ext_pipe.md
# shift_ext_pipe

Pipelined, elastic shift unit that sizes an operand to a wider result width and shifts it, following SystemVerilog self-determined/context-determined rules. Before shifting, the operand is zero- or sign-extended to OUT_W according to its signedness. The unit supports logical left, logical right and arithmetic right shifts, and reports lost significance. It sits as a reusable datapath element behind the cosim spec modules, so that constant-folded shift parameters can be checked against a clocked implementation with valid/ready flow control.

## Interface

Parameters:

- IN_W, 8: operand width.
- OUT_W, 16: result width. OUT_W >= IN_W.
- SHW, 5: shift-amount width. The amount is unsigned.
- STAGES, 2: register stages, 1..4. This is both the latency and the capacity.

Ports:

- clk  input  1  sole clock; all state is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  unit accepts this cycle.
- in_data  input  IN_W  operand.
- in_signed  input  1  1: operand is signed (sign-extend); 0: zero-extend.
- in_op  input  2  shift operation:
  - 00 is SLL.
  - 01 is SRL.
  - 10 is SRA.
  - 11 is reserved and behaves as SLL.
- in_shamt  input  SHW  shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_data  output  OUT_W  shifted result.
- out_ovf  output  1  significance lost (SLL only).

## Operation

Extension:
- x = in_data extended to OUT_W: sign-extended if in_signed, zero-extended otherwise.

Shift rules:
- SLL: x << shamt, truncated to OUT_W.
- SRL: x >> shamt, zero fill.
- SRA with in_signed=1: fill with x[OUT_W-1].
- SRA with in_signed=0: identical to SRL (>>> on an unsigned operand is logical).
- shamt >= OUT_W:
  - SLL and SRL give 0.
  - Signed SRA gives all copies of the sign bit.

Overflow (out_ovf):
- Asserted only for SLL/reserved ops; 0 for all right shifts.
- Unsigned operand: 1 if any 1 bit of x is shifted past bit OUT_W-1.
- Signed operand: 1 if the result is not equal to x·2^shamt. Equivalently, the shifted-out bits plus result bit OUT_W-1 are not all identical.
- Computed at full precision, so shamt >= OUT_W with nonzero x gives out_ovf=1.

Pipeline structure:
- The barrel shift is decomposed by shamt bit. The SHW mux levels are distributed across STAGES as evenly as possible, with earlier stages taking the extra levels.
- Each stage carries valid, partial result, remaining shamt bits, op, signed, and a sticky overflow accumulator.

Flow control:
- Stage k advances when it is empty or when stage k+1 advances. The last stage advances on out_ready.
- in_ready = stage 0 advances. This is combinational through the chain, with no extra bubble.
- Transfer occurs when valid & ready are both high, at input and at output.
- out_data and out_ovf are held stable while out_valid=1 and out_ready=0.
- Results emerge strictly in acceptance order; there is no reordering or dropping.

## Timing

Reset:
- rst=1 asynchronously clears every stage valid and zeroes all data registers.
- Therefore out_valid=0, out_data=0, out_ovf=0 and in_ready=1.
- Reset mid-operation discards every in-flight item. The first accept after deassertion behaves as if the unit were empty.

Latency and throughput:
- An item accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (visible in the cycle following edge N+STAGES-1), provided no stall.
- Full throughput is 1 item/cycle with out_ready held at 1.
- With out_ready=0, the unit accepts exactly STAGES items, then in_ready=0.

Boundary conditions:
- Full with out_ready=1: accept and retire happen in the same cycle, and in_ready stays 1.
- Empty with in_valid=0: out_valid stays 0.

## Test plan

1. IN_W=3, OUT_W=6, SHW=3, STAGES=2, out_ready=1. Operands:
   - unsigned 3'b100 SLL 1 -> 6'b001000, ovf 0.
   - signed 3'b100 SLL 1 -> 6'b111000, ovf 0.
   - out_valid is seen 2 cycles after each accept.
2. Right shifts, same configuration:
   - signed 3'b110 SRA 1 -> 6'b111111.
   - unsigned 3'b110 SRA 1 -> 6'b000011.
   - signed 3'b110 SRL 1 -> 6'b011111.
3. Overflow and large amounts:
   - signed 3'b100 SLL 3 -> 6'b100000, ovf 0.
   - signed 3'b100 SLL 4 -> 6'b000000, ovf 1.
   - unsigned 3'b100 SLL 7 -> 0, ovf 1.
   - signed 3'b100 SRA 7 -> 6'b111111, ovf 0.
4. Backpressure:
   - Hold out_ready=0 and offer 4 back-to-back items. Exactly 2 are accepted, then in_ready=0, and out_data stays stable.
   - Raise out_ready. The results drain in order, one per cycle, and in_ready rises in the same cycle out_ready rises.
5. Streaming with STAGES=4, IN_W=8, OUT_W=16: 100 random items, with random out_ready at 70% high. Every result must match a reference model, in order, with no loss or duplication.
6. Reset mid-flight:
   - Assert rst asynchronously (between edges) while 2 items are in flight. out_valid drops immediately and no stale result ever appears.
   - Accept after release: the first result arrives after STAGES cycles.
